// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline package: opcode constants, hazard-controller state
// encoding, forwarding-select encodings and the forwarding helper function.
package hazard_ctrl_pkg;

    // RV32I major opcodes used by the decode stage.
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    // Hazard controller states.
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HALT     = 2'd2
    } hz_state_e;

    // EX operand source selects.
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // Operand select for one EX source register; MEM wins over WB, x0 is
    // never forwarded because its architectural value is always zero.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] mem_rd,
        input logic       mem_wr,
        input logic [4:0] wb_rd,
        input logic       wb_wr
    );
        logic [1:0] sel;
        if (mem_wr && (mem_rd != 5'd0) && (mem_rd == rs)) begin
            sel = FWD_MEM;
        end else if (wb_wr && (wb_rd != 5'd0) && (wb_rd == rs)) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the performance counters.
// Ports: clk, rst_n (async active-low), inc (count enable), count (value).
// The counter sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);
    import hazard_ctrl_pkg::*;

    logic [W-1:0] count_r;

    // Count register: increment on inc unless already saturated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {W{1'b0}};
        end else if (inc && (count_r != {W{1'b1}})) begin
            count_r <= count_r + W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for a 5-stage in-order core.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   id_*/ex_*/mem_*/wb_* reg info   register numbers and write/read flags
//   ex_branch_taken                 redirect resolved in EX
//   dmem_req, dmem_ready            data-memory handshake from MEM
//   pc_en, if_id_en, id_ex_en, ex_mem_en     pipeline register enables
//   if_id_flush, id_ex_flush, mem_wb_flush   bubble insertion
//   fwd_a, fwd_b                    EX operand selects
//   halted                          sticky data-memory timeout
//   stall_cnt, flush_cnt            saturating performance counters
module hazard_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rs1,
    input  logic [4:0]       ex_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_reg_write,
    input  logic [4:0]       mem_rd,
    input  logic             mem_reg_write,
    input  logic [4:0]       wb_rd,
    input  logic             wb_reg_write,
    input  logic             ex_branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mem_wb_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    import hazard_ctrl_pkg::*;

    localparam int             BCW      = $clog2(TIMEOUT + 1);
    localparam logic [BCW-1:0] BUSY_ONE = BCW'(1);
    localparam logic [BCW-1:0] BUSY_END = BCW'(TIMEOUT - 1);

    hz_state_e      state_r, state_nxt_s;
    logic [BCW-1:0] busy_cnt_r, busy_cnt_nxt_s;

    logic busy_s, lu_s, branch_flush_s;
    logic pc_en_s, if_id_en_s, id_ex_en_s, ex_mem_en_s;
    logic if_id_flush_s, id_ex_flush_s, mem_wb_flush_s;

    // ex_reg_write is not needed for load-use: a load always writes rd.
    logic unused_s;
    assign unused_s = ex_reg_write;

    assign busy_s = dmem_req & ~dmem_ready;
    assign lu_s   = ex_mem_read & (ex_rd != 5'd0) &
                    ((id_use_rs1 & (id_rs1 == ex_rd)) |
                     (id_use_rs2 & (id_rs2 == ex_rd)));

    // State and consecutive-busy counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_RUN;
            busy_cnt_r <= {BCW{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            busy_cnt_r <= busy_cnt_nxt_s;
        end
    end

    // Next-state and control decode; priority busy > branch > load-use.
    always_comb begin
        state_nxt_s    = state_r;
        busy_cnt_nxt_s = busy_cnt_r;
        pc_en_s        = 1'b0;
        if_id_en_s     = 1'b0;
        id_ex_en_s     = 1'b0;
        ex_mem_en_s    = 1'b0;
        if_id_flush_s  = 1'b0;
        id_ex_flush_s  = 1'b0;
        mem_wb_flush_s = 1'b0;
        branch_flush_s = 1'b0;
        case (state_r)
            ST_RUN, ST_MEM_WAIT: begin
                if (busy_s) begin
                    // Freeze everything up to MEM, bubble into WB.
                    mem_wb_flush_s = 1'b1;
                    if (state_r == ST_RUN) begin
                        // The entering cycle is the first busy cycle.
                        state_nxt_s    = ST_MEM_WAIT;
                        busy_cnt_nxt_s = BUSY_ONE;
                    end else if (busy_cnt_r >= BUSY_END) begin
                        state_nxt_s    = ST_HALT;
                        busy_cnt_nxt_s = {BCW{1'b0}};
                    end else begin
                        busy_cnt_nxt_s = busy_cnt_r + BUSY_ONE;
                    end
                end else begin
                    state_nxt_s    = ST_RUN;
                    busy_cnt_nxt_s = {BCW{1'b0}};
                    ex_mem_en_s    = 1'b1;
                    id_ex_en_s     = 1'b1;
                    if (ex_branch_taken) begin
                        pc_en_s        = 1'b1;
                        if_id_en_s     = 1'b1;
                        if_id_flush_s  = 1'b1;
                        id_ex_flush_s  = 1'b1;
                        branch_flush_s = 1'b1;
                    end else if (lu_s) begin
                        // Hold IF/ID one cycle; the load moves on so the
                        // hazard clears after exactly one bubble.
                        id_ex_flush_s = 1'b1;
                    end else begin
                        pc_en_s    = 1'b1;
                        if_id_en_s = 1'b1;
                    end
                end
            end
            ST_HALT: begin
                state_nxt_s    = ST_HALT;
                busy_cnt_nxt_s = {BCW{1'b0}};
            end
            default: begin
                state_nxt_s    = ST_RUN;
                busy_cnt_nxt_s = {BCW{1'b0}};
            end
        endcase
    end

    // Reset forces every control output quiet.
    assign pc_en        = rst_n & pc_en_s;
    assign if_id_en     = rst_n & if_id_en_s;
    assign id_ex_en     = rst_n & id_ex_en_s;
    assign ex_mem_en    = rst_n & ex_mem_en_s;
    assign if_id_flush  = rst_n & if_id_flush_s;
    assign id_ex_flush  = rst_n & id_ex_flush_s;
    assign mem_wb_flush = rst_n & mem_wb_flush_s;
    assign fwd_a = rst_n ? fwd_sel(ex_rs1, mem_rd, mem_reg_write, wb_rd, wb_reg_write) : FWD_RF;
    assign fwd_b = rst_n ? fwd_sel(ex_rs2, mem_rd, mem_reg_write, wb_rd, wb_reg_write) : FWD_RF;
    assign halted = (state_r == ST_HALT);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   ((state_r != ST_HALT) & ~pc_en_s),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (branch_flush_s),
        .count (flush_cnt)
    );

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 16: consecutive data-memory busy cycles before halt (>=2).
REQ-002 Parameter CNT_W, default 16: width of performance counters.
REQ-003 clk  in  1  pipeline clock, rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 id_rs1, id_rs2  in  5 each  source registers of instruction in ID.
REQ-006 id_use_rs1, id_use_rs2  in  1 each  ID instruction actually reads rs1/rs2 (0 for lui/auipc/jal; rs2 also 0 for I/load/jalr).
REQ-007 ex_rs1, ex_rs2  in  5 each  source registers of instruction in EX.
REQ-008 ex_rd  in  5, ex_mem_read  in  1, ex_reg_write  in  1  EX destination, load flag, write flag.
REQ-009 mem_rd  in  5, mem_reg_write  in  1  MEM-stage destination/write flag.
REQ-010 wb_rd  in  5, wb_reg_write  in  1  WB-stage destination/write flag.
REQ-011 ex_branch_taken  in  1  taken branch/jal/jalr resolved in EX.
REQ-012 dmem_req  in  1, dmem_ready  in  1  data-memory request/ready from MEM stage.
REQ-013 pc_en, if_id_en, id_ex_en, ex_mem_en  out  1 each  pipeline register enables.
REQ-014 if_id_flush, id_ex_flush, mem_wb_flush  out  1 each  bubble insertion.
REQ-015 fwd_a, fwd_b  out  2 each  EX operand select: 00 regfile, 01 WB, 10 MEM.
REQ-016 halted  out  1  sticky memory-timeout error.
REQ-017 stall_cnt, flush_cnt  out  CNT_W each  saturating performance counters.

Function
REQ-018 Terms: busy = dmem_req & ~dmem_ready; lu = ex_mem_read & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
REQ-019 State machine RUN, MEM_WAIT, HALT; state registered, control outputs combinational from state and current inputs (zero latency).
REQ-020 Priority in RUN/MEM_WAIT: busy > ex_branch_taken > lu > normal.
REQ-021 busy: all four enables 0, mem_wb_flush 1, other flushes 0.
REQ-022 branch (no busy): all enables 1, if_id_flush 1, id_ex_flush 1, mem_wb_flush 0.
REQ-023 lu (no busy, no branch): pc_en 0, if_id_en 0, id_ex_en 1, id_ex_flush 1, ex_mem_en 1; exactly one bubble per hazard.
REQ-024 normal: all enables 1, all flushes 0.
REQ-025 RUN->MEM_WAIT on busy; MEM_WAIT->RUN in first cycle busy=0; MEM_WAIT->HALT at the edge ending the TIMEOUT-th consecutive busy cycle (count includes the RUN cycle that entered MEM_WAIT).
REQ-026 HALT: all enables 0, all flushes 0, halted 1; exits only by reset.
REQ-027 fwd_a = 10 if mem_reg_write & mem_rd!=0 & mem_rd==ex_rs1; else 01 if wb_reg_write & wb_rd!=0 & wb_rd==ex_rs1; else 00. fwd_b identical with ex_rs2. MEM beats WB; x0 never forwarded; valid in all states.
REQ-028 stall_cnt +1 every cycle pc_en=0 outside HALT; flush_cnt +1 every branch-flush cycle; both saturate at all-ones, never wrap.

Reset
REQ-029 rst_n=0 asynchronously forces state RUN, busy-run counter 0, halted 0, stall_cnt 0, flush_cnt 0.
REQ-030 While rst_n=0: all enables 0, all flushes 0, fwd_a/fwd_b 00.
REQ-031 Reset asserted mid-MEM_WAIT or in HALT discards the pending count; first cycle after release is RUN.

Structure
REQ-032 State encoding (RUN=0, MEM_WAIT=1, HALT=2) and fwd encodings (FWD_RF, FWD_WB, FWD_MEM) live in the shared pipeline package with the opcode constants.
REQ-033 One sub-module, sat_counter (parameter W; inc, count), instantiated for stall_cnt and flush_cnt; rest flat.

Verification
REQ-034 ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1 one cycle -> pc_en=0, if_id_en=0, id_ex_flush=1 that cycle, stall_cnt=1 next.
REQ-035 Same but id_use_rs1=0 (lui) -> no stall, all enables 1; ex_rd=0 case also no stall.
REQ-036 ex_branch_taken=1 with lu true same cycle -> if_id_flush=1, id_ex_flush=1, pc_en=1, flush_cnt +1, stall_cnt unchanged.
REQ-037 mem_rd=3, wb_rd=3, ex_rs1=3, both writes 1 -> fwd_a=10; mem_reg_write=0 -> 01; mem_rd=wb_rd=ex_rs1=0 -> 00.
REQ-038 TIMEOUT=4, busy held 3 cycles then ready -> freeze 3 cycles, back to RUN, halted=0; busy held 4 cycles -> halted=1 after 4th edge, all enables 0 thereafter until rst_n pulse.
REQ-039 CNT_W=4, pc_en=0 for 20 cycles -> stall_cnt holds 15; async rst_n pulse mid-MEM_WAIT -> counters 0, state RUN immediately.
